// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU datapath bus arbiter: FSM encoding and arbitration modes.
package cpu_bus_pkg;

    typedef enum logic [0:0] {
        BUS_IDLE  = 1'b0,
        BUS_OWNED = 1'b1
    } bus_state_e;

    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from a start pointer, or fixed priority with index 0 highest.
module rr_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter int unsigned SELW = $clog2(NSRC),
    parameter bit          RR   = ARB_RR
) (
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [NSRC-1:0] gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_valid
);

    logic [31:0] start;

    // Two passes model the wrap: indices at/after the pointer first, then those below it.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        start     = (RR == ARB_RR) ? 32'(ptr) : 32'd0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!gnt_valid && req[i] && (i >= start)) begin
                gnt_valid = 1'b1;
                gnt[i]    = 1'b1;
                gnt_idx   = SELW'(i);
            end
        end
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!gnt_valid && req[i] && (i < start)) begin
                gnt_valid = 1'b1;
                gnt[i]    = 1'b1;
                gnt_idx   = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Shared-bus driver: arbitrates NSRC requesters, supports lock and forced select, registers the
// granted source's word onto the bus.
module bus_arbiter_mux
    import cpu_bus_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 8,
    parameter int unsigned SELW  = $clog2(NSRC),
    parameter bit          RR    = ARB_RR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC-1:0]       req,
    input  logic                  lock,
    input  logic [NSRC*WIDTH-1:0] data_in,
    input  logic                  force_en,
    input  logic [SELW-1:0]       force_sel,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [NSRC-1:0]       grant,
    output logic [SELW-1:0]       grant_idx
);

    bus_state_e       state_q, state_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [NSRC-1:0]  grant_q, grant_d;
    logic [SELW-1:0]  idx_q, idx_d;

    logic [NSRC-1:0]  arb_gnt;
    logic [SELW-1:0]  arb_idx;
    logic             arb_valid;
    logic             force_ok;
    logic             owner_req;

    function automatic logic [WIDTH-1:0] pick(input logic [NSRC*WIDTH-1:0] words,
                                              input logic [SELW-1:0]       sel);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) begin
                w = words[i*WIDTH +: WIDTH];
            end
        end
        return w;
    endfunction

    rr_arbiter #(
        .NSRC (NSRC),
        .SELW (SELW),
        .RR   (RR)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // force_sel is wider than needed when NSRC is not a power of two.
    assign force_ok  = 32'(force_sel) < NSRC;
    assign owner_req = |(req & grant_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bus_d   = bus_q;
        valid_d = valid_q;
        grant_d = grant_q;
        idx_d   = idx_q;

        if (force_en) begin
            state_d = BUS_IDLE;
            if (force_ok) begin
                valid_d = 1'b1;
                idx_d   = force_sel;
                bus_d   = pick(data_in, force_sel);
                for (int unsigned i = 0; i < NSRC; i++) begin
                    grant_d[i] = (force_sel == SELW'(i));
                end
            end else begin
                valid_d = 1'b0;
                grant_d = '0;
                idx_d   = '0;
                bus_d   = '0;
            end
        end else if ((state_q == BUS_OWNED) && lock && owner_req) begin
            // Owner keeps the bus; its word is still re-sampled every cycle.
            valid_d = 1'b1;
            bus_d   = pick(data_in, idx_q);
        end else if (arb_valid) begin
            valid_d = 1'b1;
            grant_d = arb_gnt;
            idx_d   = arb_idx;
            bus_d   = pick(data_in, arb_idx);
            ptr_d   = (arb_idx == SELW'(NSRC - 1)) ? '0 : arb_idx + SELW'(1);
            state_d = lock ? BUS_OWNED : BUS_IDLE;
        end else begin
            valid_d = 1'b0;
            grant_d = '0;
            idx_d   = '0;
            state_d = BUS_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUS_IDLE;
            ptr_q   <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
        end
    end

    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign grant     = grant_q;
    assign grant_idx = idx_q;

endmodule
